// File: rtl/cnn_pool_stage_if.sv
// Stream bundle for the 2x2 max-pooling stage: raster input beats in, pooled elements out.
interface cnn_pool_stage_if #(
   parameter int CH = 4,
   parameter int DW = 32
);
   logic            iValid;
   logic            iSof;
   logic [CH*DW-1:0] iData;
   logic            oValid;
   logic            oLast;
   logic [CH*DW-1:0] oData;

   modport master (
      output iValid, iSof, iData,
      input  oValid, oLast, oData
   );

   modport slave (
      input  iValid, iSof, iData,
      output oValid, oLast, oData
   );
endinterface

// File: rtl/cnn_pool_stage.sv
// N-channel 2x2 stride-2 signed max-pooling over a raster stream, with a per-channel row buffer.
// Optional feature macro: POOL_RELU_EN clamps negative pooled results to zero.
module cnn_pool_stage #(
   parameter int CH   = 4,
   parameter int DW   = 32,
   parameter int IN_W = 26,
   parameter int IN_H = 26
) (
   input logic           iClk,
   input logic           iRst,
   cnn_pool_stage_if.slave bus
);

   localparam int OUT_W = IN_W / 2;
   localparam int OUT_H = IN_H / 2;
   localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int BW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int BD    = (OUT_W > 0) ? OUT_W : 1;

   localparam logic [CW-1:0] COL_LAST      = CW'(IN_W - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IN_H - 1);
   localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * OUT_W - 1);
   localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * OUT_H - 1);

   logic [CW-1:0]          colQ, colD, curCol;
   logic [RW-1:0]          rowQ, rowD, curRow;
   logic signed [DW-1:0]   holdQ [CH];
   logic signed [DW-1:0]   holdD [CH];
   logic signed [DW-1:0]   rowBuf [CH][BD];
   logic signed [DW-1:0]   inX [CH];
   logic signed [DW-1:0]   horzMax [CH];
   logic signed [DW-1:0]   poolMax [CH];
   logic [BW-1:0]          bufIdx;
   logic                   inPool, writeBuf, fire;
   logic                   oValidQ, oValidD, oLastQ, oLastD;
   logic [CH*DW-1:0]       oDataQ, oDataD;

   // A start-of-frame beat is processed as if the counters were already at the origin,
   // which discards whatever partial frame was in progress.
   always_comb begin
      curCol = bus.iSof ? '0 : colQ;
      curRow = bus.iSof ? '0 : rowQ;
      colD   = colQ;
      rowD   = rowQ;
      if (bus.iValid) begin
         if (curCol == COL_LAST) begin
            colD = '0;
            rowD = (curRow == ROW_LAST) ? '0 : curRow + 1'b1;
         end else begin
            colD = curCol + 1'b1;
            rowD = curRow;
         end
      end

      inPool   = (curCol <= COL_POOL_LAST) && (curRow <= ROW_POOL_LAST);
      bufIdx   = BW'(curCol >> 1);
      writeBuf = bus.iValid && curCol[0] && !curRow[0] && inPool;
      fire     = bus.iValid && curCol[0] && curRow[0] && inPool;
      oValidD  = fire;
      oLastD   = fire && (curCol == COL_POOL_LAST) && (curRow == ROW_POOL_LAST);
      oDataD   = oDataQ;

      for (int c = 0; c < CH; c++) begin
         inX[c]     = bus.iData[c*DW +: DW];
         horzMax[c] = (inX[c] > holdQ[c]) ? inX[c] : holdQ[c];
         poolMax[c] = (rowBuf[c][bufIdx] > horzMax[c]) ? rowBuf[c][bufIdx] : horzMax[c];
`ifdef POOL_RELU_EN
         if (poolMax[c][DW-1]) begin
            poolMax[c] = '0;
         end
`endif
         holdD[c] = (bus.iValid && !curCol[0]) ? inX[c] : holdQ[c];
         if (fire) begin
            oDataD[c*DW +: DW] = poolMax[c];
         end
      end
   end

   // Position, horizontal hold and output registers; reset discards any partial frame.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         colQ    <= '0;
         rowQ    <= '0;
         oValidQ <= 1'b0;
         oLastQ  <= 1'b0;
         oDataQ  <= '0;
         for (int c = 0; c < CH; c++) begin
            holdQ[c] <= '0;
         end
      end else begin
         colQ    <= colD;
         rowQ    <= rowD;
         oValidQ <= oValidD;
         oLastQ  <= oLastD;
         oDataQ  <= oDataD;
         for (int c = 0; c < CH; c++) begin
            holdQ[c] <= holdD[c];
         end
      end
   end

   // The row buffer is always written on an even row before the odd row reads it, so it needs no reset.
   always_ff @(posedge iClk) begin
      if (!iRst && writeBuf) begin
         for (int c = 0; c < CH; c++) begin
            rowBuf[c][bufIdx] <= horzMax[c];
         end
      end
   end

   assign bus.oValid = oValidQ;
   assign bus.oLast  = oLastQ;
   assign bus.oData  = oDataQ;

endmodule

// File: doc/cnn_pool_stage.md
# cnn_pool_stage

Parametrised N-channel 2x2/stride-2 max-pooling stage that sits directly after the multi-channel 3x3 convolution outputs in the CNN pipeline. It consumes a raster-ordered stream of signed feature-map elements, all channels in parallel, and emits the pooled feature map in raster order. A per-channel row buffer holds horizontal maxima of even rows. Optional ReLU is folded into the output register.

## Interface
- CH, 4, number of parallel channels
- DW, 32, signed element width per channel (matches convolution accumulator width)
- IN_W, 26, input feature-map width (elements per row)
- IN_H, 26, input feature-map height (rows per frame)

- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  reset; one clock; reset is synchronous and active-high
- iValid  in  1  input beat valid; no backpressure, gaps allowed
- iSof  in  1  start of frame; qualified by iValid; forces this beat to position (row 0, col 0)
- iData  in  CH*DW  channel c at bits [c*DW +: DW], signed two's complement
- oValid  out  1  pooled output valid, single-cycle pulse
- oData  out  CH*DW  pooled result, same packing as iData
- oLast  out  1  high with oValid on the final pooled element of a frame

## Operation
- Output dimensions: OUT_W = IN_W/2, OUT_H = IN_H/2 (floor). If IN_W is odd, the last column is ignored. If IN_H is odd, the last row is ignored. These beats are still counted but produce nothing.
- Position counters col (0..IN_W-1) and row (0..IN_H-1) advance only on iValid. After (IN_H-1, IN_W-1), both wrap to 0, and the next frame follows with no gap required.
- Processing of each beat, per channel, with all compares signed:
  - Even col: hold[c] <= x.
  - Odd col: h = max(hold[c], x).
    - Even row: rowbuf[c][col>>1] <= h.
    - Odd row: the output register is loaded with max(rowbuf[c][col>>1], h), and oValid is set.
- oLast = 1 when the output position is (OUT_H-1, OUT_W-1).
- iSof with iValid: counters are treated as (0,0) for this beat, and the partial frame in progress is abandoned with no output for it. iSof without iValid is ignored. iSof at a natural (0,0) has no effect.
- No arithmetic widening: max selects an input value, so the output width is DW.
- rowbuf depth is OUT_W entries per channel. rowbuf is not reset; it is always written before it is read.

## Timing
- Reset values: oValid=0, oLast=0, oData=0, col=0, row=0, hold=0.
- Reset mid-frame: all partial state is discarded. The first iValid after iRst deasserts is pixel (0,0).
- Latency: oValid is asserted exactly 1 cycle after the iValid beat at (odd row, odd col) is sampled.
- oValid is high for one cycle per pooled element. oData holds its value until the next output.
- Throughput: at most one output per 2 input beats. Gaps in iValid only delay outputs and do not alter values.
- Simultaneous iRst and iValid: reset wins and the beat is dropped.

## Configuration
- POOL_RELU_EN defined: each channel of the output register is clamped, so negative results become 0 (only the sign bit is tested).
- POOL_RELU_EN undefined: the raw signed maximum is output.

## Test plan
Test parameters: CH=2, DW=16, IN_W=4, IN_H=4. ch0 = ramp v, ch1 = -v, where v is the raster index 0..15. Macro undefined unless stated.
- Contiguous ramp frame:
  - ch0 outputs 5, 7, 13, 15; ch1 outputs 0, -2, -8, -10.
  - oValid fires the cycle after input beats 5, 7, 13, 15.
  - oLast is set only with 15.
- Same frame with random 0–3 cycle iValid gaps: identical values and order. Each output still arrives 1 cycle after its completing beat.
- IN_W=5, IN_H=5, ramp 0..24:
  - ch0 outputs 6, 8, 16, 18; oLast with 18.
  - Beats 19..24 produce no output.
  - The next frame starts cleanly at (0,0).
- iRst pulse after 6 beats of a frame, then a full frame: exactly 4 outputs, matching the contiguous ramp frame. No spurious oValid occurs during or just after reset.
- iSof asserted on the 4th beat, then 16 ramp beats: outputs 5, 7, 13, 15, with nothing emitted from the abandoned beats.
- POOL_RELU_EN defined, contiguous ramp frame: ch0 outputs 5, 7, 13, 15; ch1 outputs 0, 0, 0, 0. Two back-to-back frames give two oLast pulses and 8 outputs total.
